// File: rtl/rr_onoff_arb_pkg.sv
// rtl/rr_onoff_arb_pkg.sv - shared types, defaults and helpers for the on/off round-robin arbiter
package rr_onoff_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GRANT = 2'b01,
        GAP   = 2'b10
    } state_t;

    localparam int DEFAULT_N        = 4;
    localparam int DEFAULT_MAX_HOLD = 16;

    function automatic int wrap_inc(input int value, input int n);
        return (value == n - 1) ? 0 : value + 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin pick: first eligible index at or after ptr, modulo N
module rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         eligible,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         onehot,
    output logic [$clog2(N)-1:0] index,
    output logic                 valid
);

    localparam int IW = $clog2(N);

    logic [IW:0]   sum;
    logic [IW-1:0] pos;

    // One extra bit on the sum keeps ptr+k exact before the modulo-N fold.
    always_comb begin
        onehot = '0;
        index  = '0;
        valid  = 1'b0;
        sum    = '0;
        pos    = '0;
        for (int k = 0; k < N; k++) begin
            sum = {1'b0, ptr} + (IW + 1)'(k);
            if (sum >= (IW + 1)'(N)) begin
                sum = sum - (IW + 1)'(N);
            end
            pos = sum[IW-1:0];
            if (!valid && eligible[pos]) begin
                valid       = 1'b1;
                onehot[pos] = 1'b1;
                index       = pos;
            end
        end
    end

endmodule

// File: rtl/rr_onoff_arbiter.sv
// rtl/rr_onoff_arbiter.sv - IDLE/GRANT/GAP round-robin arbiter; RR_ONOFF_ARB_TIMEOUT_EN adds hold limit, timeout and mask
module rr_onoff_arbiter
    import rr_onoff_arb_pkg::*;
#(
    parameter int N        = DEFAULT_N,
    parameter int MAX_HOLD = DEFAULT_MAX_HOLD
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         req,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_id,
    output logic                 res_on,
    output logic                 timeout
);

    localparam int IW = $clog2(N);

    if (N < 2 || N > 8 || MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_param
        $error("rr_onoff_arbiter: N must be 2..8 and MAX_HOLD 2..255");
    end

    state_t        state;
    logic [IW-1:0] ptr;
    logic [N-1:0]  eligible;
    logic [N-1:0]  pick_onehot;
    logic [IW-1:0] pick_index;
    logic          pick_valid;

`ifdef RR_ONOFF_ARB_TIMEOUT_EN
    logic [7:0]   hold_cnt;
    logic [N-1:0] mask;
    logic         timeout_q;
    logic         hold_limit;

    assign eligible   = req & ~mask;
    assign hold_limit = (hold_cnt == 8'(MAX_HOLD - 1));
    assign timeout    = timeout_q;
`else
    assign eligible = req;
    assign timeout  = 1'b0;
`endif

    rr_pick #(.N(N)) u_pick (
        .eligible (eligible),
        .ptr      (ptr),
        .onehot   (pick_onehot),
        .index    (pick_index),
        .valid    (pick_valid)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            gnt    <= '0;
            gnt_id <= '0;
            res_on <= 1'b0;
            ptr    <= '0;
`ifdef RR_ONOFF_ARB_TIMEOUT_EN
            hold_cnt  <= '0;
            mask      <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
`ifdef RR_ONOFF_ARB_TIMEOUT_EN
            timeout_q <= 1'b0;
            // A low req sample releases that requester's mask in any state.
            mask      <= mask & req;
`endif
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        state  <= GRANT;
                        gnt    <= pick_onehot;
                        gnt_id <= pick_index;
                        res_on <= 1'b1;
`ifdef RR_ONOFF_ARB_TIMEOUT_EN
                        hold_cnt <= '0;
`endif
                    end
                end
                GRANT: begin
                    // Release wins over the hold limit when both land on the same edge.
                    if (!req[gnt_id]) begin
                        state  <= GAP;
                        gnt    <= '0;
                        res_on <= 1'b0;
                    end
`ifdef RR_ONOFF_ARB_TIMEOUT_EN
                    else if (hold_limit) begin
                        state        <= GAP;
                        gnt          <= '0;
                        res_on       <= 1'b0;
                        timeout_q    <= 1'b1;
                        mask[gnt_id] <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
`endif
                end
                GAP: begin
                    ptr   <= IW'(wrap_inc(int'(gnt_id), N));
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_onoff_arbiter.sv
// tb/tb_rr_onoff_arbiter.sv - directed and random checks of rr_onoff_arbiter against a behavioural model
module tb_rr_onoff_arbiter;

    localparam int N  = 4;
    localparam int MH = 16;
`ifdef RR_ONOFF_ARB_TIMEOUT_EN
    localparam bit TEN = 1'b1;
`else
    localparam bit TEN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] req = '0;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       res_on;
    logic       timeout;

    int tests = 0;
    int fails = 0;

    // Model: current owner (-1 when none), last owner, pending spacing cycle,
    // pointer, grant cycles served, per-requester mask, timeout pulse.
    int         m_owner = -1;
    int         m_last  = 0;
    bit         m_cool  = 1'b0;
    int         m_ptr   = 0;
    int         m_held  = 0;
    logic [3:0] m_mask  = '0;
    logic       m_tout  = 1'b0;

    rr_onoff_arbiter #(.N(N), .MAX_HOLD(MH)) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .res_on  (res_on),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    task automatic model_update(input logic [3:0] r, input logic rs);
        logic [3:0] old_mask;
        int         idx;
        if (rs) begin
            m_owner = -1; m_last = 0; m_cool = 1'b0; m_ptr = 0;
            m_held = 0; m_mask = '0; m_tout = 1'b0;
            return;
        end
        old_mask = m_mask;
        m_tout   = 1'b0;
        m_mask   = m_mask & r;
        if (m_owner >= 0) begin
            m_held++;
            if (!r[m_owner]) begin
                m_last = m_owner; m_owner = -1; m_cool = 1'b1;
            end else if (TEN && m_held == MH) begin
                m_tout = 1'b1;
                m_mask[m_owner] = 1'b1;
                m_last = m_owner; m_owner = -1; m_cool = 1'b1;
            end
        end else if (m_cool) begin
            m_ptr  = (m_last + 1) % N;
            m_cool = 1'b0;
        end else begin
            for (int k = 0; k < N; k++) begin
                idx = (m_ptr + k) % N;
                if (m_owner < 0 && r[idx] && !old_mask[idx]) begin
                    m_owner = idx; m_last = idx; m_held = 0;
                end
            end
        end
    endtask

    task automatic check_model(input string tag);
        logic [3:0] e_gnt;
        e_gnt = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
        tests++;
        assert (gnt === e_gnt) else begin
            fails++; $error("FAIL %s gnt observed=%b expected=%b", tag, gnt, e_gnt);
        end
        tests++;
        assert (gnt_id === 2'(m_last)) else begin
            fails++; $error("FAIL %s gnt_id observed=%0d expected=%0d", tag, gnt_id, m_last);
        end
        tests++;
        assert (res_on === (m_owner >= 0)) else begin
            fails++; $error("FAIL %s res_on observed=%b expected=%b", tag, res_on, m_owner >= 0);
        end
        tests++;
        assert (timeout === m_tout) else begin
            fails++; $error("FAIL %s timeout observed=%b expected=%b", tag, timeout, m_tout);
        end
    endtask

    task automatic step(input logic [3:0] r, input logic rs, input string tag);
        req   = r;
        reset = rs;
        @(posedge clk);
        model_update(r, rs);
        #1;
        check_model(tag);
    endtask

    task automatic expect_gnt(input logic [3:0] e, input string tag);
        tests++;
        assert (gnt === e) else begin
            fails++; $error("FAIL %s gnt observed=%b expected=%b", tag, gnt, e);
        end
    endtask

    task automatic expect_bit(input logic obs, input logic e, input string tag);
        tests++;
        assert (obs === e) else begin
            fails++; $error("FAIL %s observed=%b expected=%b", tag, obs, e);
        end
    endtask

    int grant_cycles;
    int pulses;
    logic [3:0] rnd_req;

    initial begin
        step(4'b0000, 1'b1, "reset");
        step(4'b0000, 1'b1, "reset");
        expect_gnt(4'b0000, "reset_gnt");
        expect_bit(res_on, 1'b0, "reset_res_on");

        // First grant and release ordering
        step(4'b0101, 1'b0, "first");
        expect_gnt(4'b0001, "first_gnt");
        expect_bit(res_on, 1'b1, "first_res_on");
        step(4'b0101, 1'b0, "hold0");
        step(4'b0100, 1'b0, "rel0_gap");
        expect_gnt(4'b0000, "gap_gnt");
        step(4'b0101, 1'b0, "idle");
        expect_gnt(4'b0000, "idle_gnt");
        step(4'b0101, 1'b0, "grant2");
        expect_gnt(4'b0100, "grant2_gnt");

        // Wrap-around: requester 2 releases so ptr lands on 3
        step(4'b1001, 1'b0, "wrap_gap");
        step(4'b1001, 1'b0, "wrap_idle");
        step(4'b1001, 1'b0, "wrap_g3");
        expect_gnt(4'b1000, "wrap_gnt3");
        step(4'b0001, 1'b0, "wrap_gap2");
        step(4'b0001, 1'b0, "wrap_idle2");
        step(4'b0001, 1'b0, "wrap_g0");
        expect_gnt(4'b0001, "wrap_gnt0");
        step(4'b0000, 1'b0, "wrap_rel");
        step(4'b0000, 1'b0, "wrap_idle3");

        // Requester 1 holds indefinitely
        grant_cycles = 0;
        pulses = 0;
        for (int c = 0; c < 40; c++) begin
            step(4'b0010, 1'b0, "hold_long");
            if (gnt === 4'b0010) grant_cycles++;
            if (timeout === 1'b1) pulses++;
        end
        tests++;
        assert (grant_cycles == (TEN ? MH : 40)) else begin
            fails++; $error("FAIL hold_cycles observed=%0d expected=%0d", grant_cycles, TEN ? MH : 40);
        end
        tests++;
        assert (pulses == (TEN ? 1 : 0)) else begin
            fails++; $error("FAIL timeout_pulses observed=%0d expected=%0d", pulses, TEN ? 1 : 0);
        end
        step(4'b0000, 1'b0, "toggle_low");
        step(4'b0000, 1'b0, "toggle_low2");
        step(4'b0000, 1'b0, "toggle_low3");
        step(4'b0010, 1'b0, "toggle_high");
        expect_gnt(4'b0010, "regrant1");

        // Release on exactly the hold-limit cycle
        for (int c = 0; c < MH - 1; c++) step(4'b0010, 1'b0, "edge_hold");
        expect_bit(res_on, 1'b1, "edge_last_cycle");
        step(4'b0000, 1'b0, "edge_release");
        expect_bit(timeout, 1'b0, "edge_no_timeout");
        step(4'b0010, 1'b0, "edge_idle");
        step(4'b0010, 1'b0, "edge_regrant");
        expect_gnt(4'b0010, "edge_mask_clear");

        // Reset mid-grant, then arbitration restarts from ptr 0
        step(4'b1111, 1'b0, "pre_rst");
        step(4'b1111, 1'b1, "mid_rst");
        expect_gnt(4'b0000, "rst_gnt");
        expect_bit(res_on, 1'b0, "rst_res_on");
        expect_bit(gnt_id == 2'd0, 1'b1, "rst_gnt_id");
        step(4'b1111, 1'b0, "post_rst");
        expect_gnt(4'b0001, "post_rst_gnt");

        // Random traffic: sticky requests with occasional toggles and resets
        rnd_req = '0;
        for (int c = 0; c < 1500; c++) begin
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 7) == 0) rnd_req[b] = ~rnd_req[b];
            end
            step(rnd_req, ($urandom_range(0, 149) == 0), "random");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
